// File: rtl/irq_pkg.sv
// irq_pkg: shared definitions for the nested interrupt controller.
//   irq_state_e   - request FSM states (IDLE, REQUEST, BLANK)
//   DEF_*         - default address width, vector base and vector stride
//   vec_addr()    - vector address of a source index (caller truncates to ADDR_W)
package irq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQUEST,
    BLANK
  } irq_state_e;

  localparam int unsigned DEF_ADDR_W     = 10;
  localparam int unsigned DEF_VEC_BASE   = 'h3C0;
  localparam int unsigned DEF_VEC_STRIDE = 4;

  function automatic int unsigned vec_addr(input int unsigned base,
                                           input int unsigned stride,
                                           input int unsigned idx);
    return base + idx * stride;
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// irq_prio_enc: combinational lowest-index-wins priority encoder.
//   req   [N-1:0]         request vector, bit 0 is highest priority
//   valid                 any bit of req set
//   index [$clog2(N)-1:0] lowest set bit of req (0 when !valid)
module irq_prio_enc #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]         req,
  output logic                 valid,
  output logic [$clog2(N)-1:0] index
);

  always_comb begin
    valid = 1'b0;
    index = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (req[i] && !valid) begin
        valid = 1'b1;
        index = ($clog2(N))'(i);
      end
    end
  end

endmodule

// File: rtl/irq_ctrl_nested.sv
// irq_ctrl_nested: multi-source interrupt controller with nested in-service stack.
//   clk, reset (sync, active-low)
//   irq_in          raw source lines; rising edge latches pending (level mode: pending follows irq_in)
//   irq_mask        1 = source enabled (registered, applies from the following cycle)
//   irq_ack         CPU took irq_vec this cycle
//   s_finish_interr return-from-interrupt pulse
//   irq_req/irq_vec registered request and vector to the CPU PC mux
//   active_src      top of in-service stack (0 when empty); in_service = depth != 0
//   depth           nesting level; pending = latched pending bits
//   err_underflow   sticky: finish seen with empty stack
// Optional: define IRQ_LEVEL_EN for level-sensitive sources.
module irq_ctrl_nested
  import irq_pkg::*;
#(
  parameter int unsigned N_SRC      = 4,
  parameter int unsigned ADDR_W     = DEF_ADDR_W,
  parameter int unsigned NEST       = 2,
  parameter int unsigned VEC_BASE   = DEF_VEC_BASE,
  parameter int unsigned VEC_STRIDE = DEF_VEC_STRIDE
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_SRC-1:0]           irq_in,
  input  logic [N_SRC-1:0]           irq_mask,
  input  logic                       irq_ack,
  input  logic                       s_finish_interr,
  output logic                       irq_req,
  output logic [ADDR_W-1:0]          irq_vec,
  output logic [$clog2(N_SRC)-1:0]   active_src,
  output logic                       in_service,
  output logic [$clog2(NEST+1)-1:0]  depth,
  output logic [N_SRC-1:0]           pending,
  output logic                       err_underflow
);

  localparam int unsigned SRC_W = $clog2(N_SRC);
  localparam int unsigned DEP_W = $clog2(NEST + 1);

  irq_state_e        state, state_next;
  logic [SRC_W-1:0]  req_src, req_src_next;
  logic [SRC_W-1:0]  best;
  logic              best_valid;
  logic [N_SRC-1:0]  mask_q;
  logic [N_SRC-1:0]  pending_next;
  logic              allowed, req_ok, take, finish_ok, room;
  logic [ADDR_W-1:0] irq_vec_next;
  logic [SRC_W-1:0]  stk [NEST];

`ifndef IRQ_LEVEL_EN
  logic [N_SRC-1:0]  irq_prev;
`endif

  irq_prio_enc #(.N(N_SRC)) u_prio (
    .req   (pending & mask_q),
    .valid (best_valid),
    .index (best)
  );

  assign in_service = (depth != '0);
  assign active_src = in_service ? stk[depth - DEP_W'(1)] : '0;
  assign room       = (depth < DEP_W'(NEST));
  assign take       = irq_req && irq_ack;
  assign finish_ok  = s_finish_interr && in_service;

  // Equal priority never preempts: strict less-than against the stack top.
  assign allowed = best_valid && room && (!in_service || best < active_src);
  assign req_ok  = pending[req_src] && mask_q[req_src] && room &&
                   (!in_service || req_src < active_src);

  always_comb begin
`ifdef IRQ_LEVEL_EN
    pending_next = irq_in;
`else
    pending_next = pending;
    if (take) pending_next[req_src] = 1'b0;
    // A fresh edge on the source being acked wins over the clear.
    pending_next = pending_next | (irq_in & ~irq_prev);
`endif
  end

  always_comb begin
    state_next   = state;
    req_src_next = req_src;
    case (state)
      IDLE: begin
        if (allowed) begin
          state_next   = REQUEST;
          req_src_next = best;
        end
      end
      REQUEST: begin
        if (take) begin
          state_next = BLANK;
        end else if (allowed && best < req_src) begin
          req_src_next = best;
        end else if (!req_ok) begin
          state_next = IDLE;
        end
      end
      BLANK:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
    irq_vec_next = ADDR_W'(vec_addr(VEC_BASE, VEC_STRIDE, 32'(req_src_next)));
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= IDLE;
      req_src       <= '0;
      irq_req       <= 1'b0;
      irq_vec       <= ADDR_W'(VEC_BASE);
      mask_q        <= '0;
      pending       <= '0;
      depth         <= '0;
      err_underflow <= 1'b0;
      for (int unsigned i = 0; i < NEST; i++) stk[i] <= '0;
`ifndef IRQ_LEVEL_EN
      irq_prev      <= '0;
`endif
    end else begin
      state   <= state_next;
      req_src <= req_src_next;
      irq_req <= (state_next == REQUEST);
      irq_vec <= irq_vec_next;
      mask_q  <= irq_mask;
      pending <= pending_next;
`ifndef IRQ_LEVEL_EN
      irq_prev <= irq_in;
`endif
      if (s_finish_interr && !in_service) err_underflow <= 1'b1;
      // Finish together with ack: pop then push collapses to overwriting the top.
      case ({take, finish_ok})
        2'b10: begin
          stk[depth] <= req_src;
          depth      <= depth + DEP_W'(1);
        end
        2'b01: depth <= depth - DEP_W'(1);
        2'b11: stk[depth - DEP_W'(1)] <= req_src;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_irq_ctrl_nested.sv
module tb_irq_ctrl_nested;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] irq_in;
  logic [3:0] irq_mask;
  logic       irq_ack;
  logic       s_finish_interr;
  logic       irq_req;
  logic [9:0] irq_vec;
  logic [1:0] active_src;
  logic       in_service;
  logic [1:0] depth;
  logic [3:0] pending;
  logic       err_underflow;

  int n_checks = 0;
  int n_fail   = 0;

  irq_ctrl_nested #(
    .N_SRC(4), .ADDR_W(10), .NEST(2), .VEC_BASE('h3C0), .VEC_STRIDE(4)
  ) dut (
    .clk(clk), .reset(reset), .irq_in(irq_in), .irq_mask(irq_mask),
    .irq_ack(irq_ack), .s_finish_interr(s_finish_interr),
    .irq_req(irq_req), .irq_vec(irq_vec), .active_src(active_src),
    .in_service(in_service), .depth(depth), .pending(pending),
    .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b0; irq_in = '0; irq_mask = '0; irq_ack = 1'b0; s_finish_interr = 1'b0;
    tick(2);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (irq_req !== 1'b0)    begin n_fail++; $display("FAIL rst_req: got %b want 0", irq_req); end
    n_checks++; if (irq_vec !== 10'h3C0) begin n_fail++; $display("FAIL rst_vec: got %h want 3c0", irq_vec); end
    n_checks++; if (depth !== 2'd0)      begin n_fail++; $display("FAIL rst_depth: got %0d want 0", depth); end
    n_checks++; if (active_src !== 2'd0) begin n_fail++; $display("FAIL rst_active: got %0d want 0", active_src); end
    n_checks++; if (pending !== 4'h0)    begin n_fail++; $display("FAIL rst_pending: got %h want 0", pending); end
    n_checks++; if (err_underflow !== 1'b0 || in_service !== 1'b0) begin n_fail++; $display("FAIL rst_flags: got err=%b insvc=%b want 0 0", err_underflow, in_service); end
  endtask

  task automatic test_single();
    irq_mask = 4'hF; tick();
    irq_in = 4'b0100; tick();
    n_checks++; if (pending !== 4'b0100 || irq_req !== 1'b0) begin n_fail++; $display("FAIL single_pend: got pend=%h req=%b want 4 0", pending, irq_req); end
    irq_in = '0; tick();
    n_checks++; if (irq_req !== 1'b1 || irq_vec !== 10'h3C8) begin n_fail++; $display("FAIL single_req: got req=%b vec=%h want 1 3c8", irq_req, irq_vec); end
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    n_checks++; if (pending !== 4'h0 || depth !== 2'd1 || active_src !== 2'd2 || irq_req !== 1'b0 || in_service !== 1'b1)
      begin n_fail++; $display("FAIL single_ack: got pend=%h d=%0d act=%0d req=%b insvc=%b want 0 1 2 0 1", pending, depth, active_src, irq_req, in_service); end
    tick();
    n_checks++; if (irq_req !== 1'b0) begin n_fail++; $display("FAIL single_blank: got %b want 0", irq_req); end
    s_finish_interr = 1'b1; tick(); s_finish_interr = 1'b0;
    n_checks++; if (depth !== 2'd0 || active_src !== 2'd0) begin n_fail++; $display("FAIL single_fin: got d=%0d act=%0d want 0 0", depth, active_src); end
    // ack without a request must be ignored
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    n_checks++; if (depth !== 2'd0 || err_underflow !== 1'b0) begin n_fail++; $display("FAIL stray_ack: got d=%0d err=%b want 0 0", depth, err_underflow); end
  endtask

  task automatic test_priority();
    irq_in = 4'b1010; tick(); irq_in = '0; tick();
    n_checks++; if (irq_req !== 1'b1 || irq_vec !== 10'h3C4) begin n_fail++; $display("FAIL prio_vec: got req=%b vec=%h want 1 3c4", irq_req, irq_vec); end
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    n_checks++; if (depth !== 2'd1 || active_src !== 2'd1 || pending !== 4'b1000) begin n_fail++; $display("FAIL prio_ack: got d=%0d act=%0d pend=%h want 1 1 8", depth, active_src, pending); end
    tick(4);
    n_checks++; if (irq_req !== 1'b0) begin n_fail++; $display("FAIL prio_hold: got req=%b want 0", irq_req); end
    s_finish_interr = 1'b1; tick(); s_finish_interr = 1'b0;
    tick();
    n_checks++; if (irq_req !== 1'b1 || irq_vec !== 10'h3CC) begin n_fail++; $display("FAIL prio_low: got req=%b vec=%h want 1 3cc", irq_req, irq_vec); end
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    n_checks++; if (depth !== 2'd1 || active_src !== 2'd3 || pending !== 4'h0) begin n_fail++; $display("FAIL prio_ack3: got d=%0d act=%0d pend=%h want 1 3 0", depth, active_src, pending); end
    s_finish_interr = 1'b1; tick(); s_finish_interr = 1'b0;
  endtask

  task automatic test_nesting();
    // source 3 in service, then source 1 preempts
    irq_in = 4'b1000; tick(); irq_in = '0; tick();
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    irq_in = 4'b0010; tick(); irq_in = '0; tick();
    n_checks++; if (irq_req !== 1'b1 || irq_vec !== 10'h3C4) begin n_fail++; $display("FAIL nest_req1: got req=%b vec=%h want 1 3c4", irq_req, irq_vec); end
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    n_checks++; if (depth !== 2'd2 || active_src !== 2'd1) begin n_fail++; $display("FAIL nest_d2: got d=%0d act=%0d want 2 1", depth, active_src); end
    // source 0 outranks the top but the stack is full
    irq_in = 4'b0001; tick(); irq_in = '0; tick(4);
    n_checks++; if (irq_req !== 1'b0 || pending !== 4'b0001) begin n_fail++; $display("FAIL nest_full: got req=%b pend=%h want 0 1", irq_req, pending); end
    s_finish_interr = 1'b1; tick(); s_finish_interr = 1'b0;
    n_checks++; if (depth !== 2'd1 || active_src !== 2'd3) begin n_fail++; $display("FAIL nest_pop: got d=%0d act=%0d want 1 3", depth, active_src); end
    tick();
    n_checks++; if (irq_req !== 1'b1 || irq_vec !== 10'h3C0) begin n_fail++; $display("FAIL nest_req0: got req=%b vec=%h want 1 3c0", irq_req, irq_vec); end
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    n_checks++; if (depth !== 2'd2 || active_src !== 2'd0) begin n_fail++; $display("FAIL nest_push0: got d=%0d act=%0d want 2 0", depth, active_src); end
    s_finish_interr = 1'b1; tick(2); s_finish_interr = 1'b0;
    n_checks++; if (depth !== 2'd0) begin n_fail++; $display("FAIL nest_empty: got d=%0d want 0", depth); end
  endtask

  task automatic test_mask();
    irq_mask = '0; tick();
    irq_in = 4'b0010; tick(); irq_in = '0; tick(3);
    n_checks++; if (pending !== 4'b0010 || irq_req !== 1'b0) begin n_fail++; $display("FAIL mask_hold: got pend=%h req=%b want 2 0", pending, irq_req); end
    irq_mask = 4'b0010; tick();
    n_checks++; if (irq_req !== 1'b0) begin n_fail++; $display("FAIL mask_lat1: got req=%b want 0", irq_req); end
    tick();
    n_checks++; if (irq_req !== 1'b1 || irq_vec !== 10'h3C4) begin n_fail++; $display("FAIL mask_lat2: got req=%b vec=%h want 1 3c4", irq_req, irq_vec); end
    irq_mask = '0; tick(2);
    n_checks++; if (irq_req !== 1'b0 || pending !== 4'b0010) begin n_fail++; $display("FAIL mask_drop: got req=%b pend=%h want 0 2", irq_req, pending); end
    irq_mask = 4'hF; tick(2);
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    n_checks++; if (depth !== 2'd1 || active_src !== 2'd1) begin n_fail++; $display("FAIL mask_take: got d=%0d act=%0d want 1 1", depth, active_src); end
    s_finish_interr = 1'b1; tick(); s_finish_interr = 1'b0;
  endtask

  task automatic test_corners();
    // underflow
    s_finish_interr = 1'b1; tick(); s_finish_interr = 1'b0;
    tick(2);
    n_checks++; if (err_underflow !== 1'b1 || depth !== 2'd0) begin n_fail++; $display("FAIL underflow: got err=%b d=%0d want 1 0", err_underflow, depth); end
    // simultaneous ack and finish
    irq_in = 4'b0100; tick(); irq_in = '0; tick();
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    irq_in = 4'b0001; tick(); irq_in = '0; tick();
    n_checks++; if (irq_req !== 1'b1 || irq_vec !== 10'h3C0) begin n_fail++; $display("FAIL sim_req: got req=%b vec=%h want 1 3c0", irq_req, irq_vec); end
    irq_ack = 1'b1; s_finish_interr = 1'b1; tick(); irq_ack = 1'b0; s_finish_interr = 1'b0;
    n_checks++; if (depth !== 2'd1 || active_src !== 2'd0) begin n_fail++; $display("FAIL sim_ackfin: got d=%0d act=%0d want 1 0", depth, active_src); end
    s_finish_interr = 1'b1; tick(); s_finish_interr = 1'b0;
    // new edge on the source being acked keeps it pending; no equal-priority re-entry
    irq_in = 4'b1000; tick(); irq_in = '0; tick();
    irq_in = 4'b1000; irq_ack = 1'b1; tick(); irq_ack = 1'b0; irq_in = '0;
    n_checks++; if (pending !== 4'b1000 || depth !== 2'd1 || active_src !== 2'd3) begin n_fail++; $display("FAIL ack_edge: got pend=%h d=%0d act=%0d want 8 1 3", pending, depth, active_src); end
    tick(4);
    n_checks++; if (irq_req !== 1'b0) begin n_fail++; $display("FAIL no_reenter: got req=%b want 0", irq_req); end
    s_finish_interr = 1'b1; tick(); s_finish_interr = 1'b0;
    tick();
    n_checks++; if (irq_req !== 1'b1 || irq_vec !== 10'h3CC) begin n_fail++; $display("FAIL reenter: got req=%b vec=%h want 1 3cc", irq_req, irq_vec); end
    // reset while requesting with a source in service
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    irq_in = 4'b0010; tick(); irq_in = '0; tick();
    reset = 1'b0; tick(); reset = 1'b1;
    n_checks++; if (irq_req !== 1'b0 || irq_vec !== 10'h3C0 || depth !== 2'd0 || active_src !== 2'd0 || pending !== 4'h0 || err_underflow !== 1'b0)
      begin n_fail++; $display("FAIL mid_reset: got req=%b vec=%h d=%0d act=%0d pend=%h err=%b", irq_req, irq_vec, depth, active_src, pending, err_underflow); end
  endtask

  task automatic test_level();
    irq_mask = 4'hF; tick();
    irq_in = 4'b0001; tick(2);
    n_checks++; if (irq_req !== 1'b1 || irq_vec !== 10'h3C0) begin n_fail++; $display("FAIL lvl_req: got req=%b vec=%h want 1 3c0", irq_req, irq_vec); end
    irq_ack = 1'b1; tick(); irq_ack = 1'b0; tick(3);
    n_checks++; if (irq_req !== 1'b0 || depth !== 2'd1 || pending !== 4'b0001) begin n_fail++; $display("FAIL lvl_svc: got req=%b d=%0d pend=%h want 0 1 1", irq_req, depth, pending); end
    s_finish_interr = 1'b1; tick(); s_finish_interr = 1'b0; tick();
    n_checks++; if (irq_req !== 1'b1) begin n_fail++; $display("FAIL lvl_refire: got req=%b want 1", irq_req); end
    irq_ack = 1'b1; tick(); irq_ack = 1'b0; irq_in = '0; tick();
    s_finish_interr = 1'b1; tick(); s_finish_interr = 1'b0; tick(3);
    n_checks++; if (irq_req !== 1'b0 || depth !== 2'd0) begin n_fail++; $display("FAIL lvl_release: got req=%b d=%0d want 0 0", irq_req, depth); end
  endtask

  initial begin
    test_reset();
`ifdef IRQ_LEVEL_EN
    test_level();
`else
    test_single();
    test_priority();
    test_nesting();
    test_mask();
    test_corners();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
